// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// aes_pkg : FSM encodings and AES forward/inverse S-box tables
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`define AES_BYTE(v, i) v[8*(i) +: 8]

package aes_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Entry 0 occupies the most significant byte of each table.
    localparam logic [2047:0] SBOX_FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_FWD_TBL[8*(255 - int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return SBOX_INV_TBL[8*(255 - int'(x)) +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox_lane.sv
//------------------------------------------------------------------------------
// aes_sbox_lane : one combinational S-box lane, inverse table optional
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter int INV_EN = 1
) (
    input  logic [7:0] byte_i,
    input  logic       inv_i,
    output logic [7:0] byte_o
);

    if (INV_EN != 0) begin : g_inv
        assign byte_o = inv_i ? sbox_inv(byte_i) : sbox_fwd(byte_i);
    end else begin : g_fwd_only
        logic w_unused_inv;
        assign w_unused_inv = inv_i;
        assign byte_o       = sbox_fwd(byte_i);
    end

endmodule

`default_nettype wire

// File: rtl/aes_subbytes_iter.sv
//------------------------------------------------------------------------------
// aes_subbytes_iter : iterative SubBytes, NUM_SBOX lanes over NUM_BYTES/NUM_SBOX cycles
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_subbytes_iter
    import aes_pkg::*;
#(
    parameter int NUM_BYTES = 16,
    parameter int NUM_SBOX  = 4,
    parameter int INV_EN    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int ITER  = NUM_BYTES / NUM_SBOX;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    if ((NUM_SBOX < 1) || (NUM_SBOX > NUM_BYTES) || (NUM_BYTES % NUM_SBOX != 0)) begin : g_param_check
        $error("aes_subbytes_iter: NUM_SBOX must divide NUM_BYTES");
    end

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [8*NUM_BYTES-1:0] work_q, work_d;
    logic [8*NUM_BYTES-1:0] out_data_q, out_data_d;
    logic                   inv_q, inv_d;
    logic [8*NUM_BYTES-1:0] w_work_sub;
    logic [7:0]             w_lane_out [NUM_SBOX];

    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
        aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
            .byte_i (`AES_BYTE(work_q, int'(cnt_q) * NUM_SBOX + l)),
            .inv_i  (inv_q),
            .byte_o (w_lane_out[l])
        );
    end

    // Current slice written back in place; other bytes pass through untouched.
    always_comb begin
        w_work_sub = work_q;
        for (int l = 0; l < NUM_SBOX; l++) begin
            `AES_BYTE(w_work_sub, int'(cnt_q) * NUM_SBOX + l) = w_lane_out[l];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        out_data_d = out_data_q;
        inv_d      = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    inv_d   = in_inv & (INV_EN != 0);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = w_work_sub;
                if (cnt_q == CNT_LAST) begin
                    out_data_d = w_work_sub;
                    cnt_d      = '0;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            out_data_q <= '0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            out_data_q <= out_data_d;
            inv_q      <= inv_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_aes_subbytes_iter.sv
//------------------------------------------------------------------------------
// tb_aes_subbytes_iter : scoreboard bench for the iterative SubBytes engine
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_subbytes_iter;

    localparam int EXP_LAT = 4;

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    logic         p_valid = 1'b0;
    logic [127:0] p_data = '0;
    logic         p_inv = 1'b0;
    logic         s16_ir, s16_ov, s16_bz, s1_ir, s1_ov, s1_bz, ni_ir, ni_ov, ni_bz;
    logic [127:0] s16_od, s1_od, ni_od;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic prev_ov = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_subbytes_iter #(.NUM_BYTES(16), .NUM_SBOX(4), .INV_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );
    aes_subbytes_iter #(.NUM_BYTES(16), .NUM_SBOX(16), .INV_EN(1)) u_s16 (
        .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(s16_ir), .in_data(p_data),
        .in_inv(p_inv), .out_valid(s16_ov), .out_ready(1'b1), .out_data(s16_od), .busy(s16_bz)
    );
    aes_subbytes_iter #(.NUM_BYTES(16), .NUM_SBOX(1), .INV_EN(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(s1_ir), .in_data(p_data),
        .in_inv(p_inv), .out_valid(s1_ov), .out_ready(1'b1), .out_data(s1_od), .busy(s1_bz)
    );
    aes_subbytes_iter #(.NUM_BYTES(16), .NUM_SBOX(4), .INV_EN(0)) u_ni (
        .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(ni_ir), .in_data(p_data),
        .in_inv(p_inv), .out_valid(ni_ov), .out_ready(1'b1), .out_data(ni_od), .busy(ni_bz)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: latency on each rising out_valid, data on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 128'(out_valid), 128'(0));
                else chk("latency", 128'(cyc - sb[0].acc), 128'(EXP_LAT));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                chk("out_data", out_data, sb[0].data);
                void'(sb.pop_front());
            end
        end
        prev_ov <= rst ? 1'b0 : out_valid;
    end

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp, input bit track);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_inv = inv;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("send_in_ready_timeout", 128'(in_ready), 128'(1));
        if (track) sb.push_back('{exp, cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_inv   = ~inv;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) break;
        end
        chk("drain_scoreboard_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] hold_a;
        int   acc, lat16, lat1, latni;
        logic [127:0] d16, d1, dni;
        bit   saw_ov;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Forward and inverse substitution
        send({16{8'h53}}, 1'b0, {16{8'hed}}, 1'b1);
        send({8'hff, {14{8'h01}}, 8'h00}, 1'b0, {8'h16, {14{8'h7c}}, 8'h63}, 1'b1);
        send({16{8'hed}}, 1'b1, {16{8'h53}}, 1'b1);
        send({8'h16, {14{8'hed}}, 8'h63}, 1'b1, {8'hff, {14{8'h53}}, 8'h00}, 1'b1);
        drain();

        // Back-pressure with a second block waiting
        @(posedge clk); #1; out_ready = 1'b0;
        send({8'hff, {14{8'h01}}, 8'h00}, 1'b0, {8'h16, {14{8'h7c}}, 8'h63}, 1'b1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("bp_out_valid_seen", 128'(out_valid), 128'(1));
        hold_a = {8'h16, {14{8'h7c}}, 8'h63};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = {16{8'h53}}; in_inv = 1'b0;
            @(negedge clk);
            chk("bp_out_data_stable", out_data, hold_a);
            chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        send({16{8'h53}}, 1'b0, {16{8'hed}}, 1'b1);
        drain();

        // Reset while cnt==2: block is dropped silently
        send({16{8'h11}}, 1'b0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_busy_before_rst", 128'(busy), 128'(1));
        chk("midrun_in_ready_in_rst", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        saw_ov = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) saw_ov = 1'b1;
        end
        chk("midrun_no_out_valid", 128'(saw_ov), 128'(0));
        chk("midrun_busy_idle", 128'(busy), 128'(0));
        send({16{8'h00}}, 1'b0, {16{8'h63}}, 1'b1);
        drain();

        // Parameter variants, all fed the same block with in_inv=1
        lat16 = -1; lat1 = -1; latni = -1;
        d16 = '0; d1 = '0; dni = '0;
        @(posedge clk); #1;
        p_valid = 1'b1; p_data = {16{8'hed}}; p_inv = 1'b1;
        @(negedge clk);
        chk("param_in_ready", 128'({s16_ir, s1_ir, ni_ir}), 128'(3'b111));
        acc = cyc + 1;
        @(posedge clk); #1;
        p_valid = 1'b0; p_inv = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (s16_ov && lat16 < 0) begin lat16 = cyc - acc; d16 = s16_od; end
            if (s1_ov && lat1 < 0) begin lat1 = cyc - acc; d1 = s1_od; end
            if (ni_ov && latni < 0) begin latni = cyc - acc; dni = ni_od; end
        end
        chk("s16_latency", 128'(lat16), 128'(1));
        chk("s16_data", d16, {16{8'h53}});
        chk("s1_latency", 128'(lat1), 128'(16));
        chk("s1_data", d1, {16{8'h53}});
        chk("noinv_latency", 128'(latni), 128'(4));
        chk("noinv_forward_data", dni, {16{8'h55}});
        chk("noinv_data_retained", ni_od, {16{8'h55}});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
